// File: rtl/regfile_write_arbiter.sv
// Two-requester write arbiter in front of a register file.
//
// Each requester has a one-entry pending buffer. Buffered writes are granted
// one per cycle. When both buffers are pending, a round-robin pointer picks
// the requester that was not granted most recently. The granted write is
// issued to the register file as a registered write.
//
// Ports
//   clk, reset_n                       clock, asynchronous active-low reset
//   reqN_valid/addr/data (N = 0, 1)    write request from requester N
//   reqN_ready                         requester N may transfer this cycle
//   stall                              blocks all grants while high
//   regwrite/writeaddr/writedata       registered write port to the regfile
//   zero_drop                          one-cycle pulse: a granted write to r0
//                                      was suppressed
module regfile_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              stall,
    output logic              regwrite,
    output logic [ADDR_W-1:0] writeaddr,
    output logic [DATA_W-1:0] writedata,
    output logic              zero_drop
);

    logic [1:0]             r_pend;
    logic [1:0][ADDR_W-1:0] r_addr;
    logic [1:0][DATA_W-1:0] r_data;
    logic                   r_rr;      // requester to favour on contention

    logic [1:0]             w_grant;
    logic [1:0]             w_ready;
    logic [1:0]             w_xfer;
    logic [1:0][ADDR_W-1:0] w_in_addr;
    logic [1:0][DATA_W-1:0] w_in_data;
    logic [ADDR_W-1:0]      w_gaddr;
    logic [DATA_W-1:0]      w_gdata;

    assign w_in_addr = {req1_addr, req0_addr};
    assign w_in_data = {req1_data, req0_data};

    always_comb begin
        w_grant = 2'b00;
        if (!stall) begin
            case (r_pend)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11:   w_grant = r_rr ? 2'b10 : 2'b01;
                default: w_grant = 2'b00;
            endcase
        end
    end

    // A buffer that drains this cycle can refill at the same edge, which is
    // what gives one write per cycle from a single busy requester.
    assign w_ready    = ~r_pend | w_grant;
    assign w_xfer     = {req1_valid, req0_valid} & w_ready;
    assign req0_ready = w_ready[0];
    assign req1_ready = w_ready[1];

    assign w_gaddr = w_grant[1] ? r_addr[1] : r_addr[0];
    assign w_gdata = w_grant[1] ? r_data[1] : r_data[0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend <= '0;
            r_addr <= '0;
            r_data <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_xfer[i]) begin
                    r_pend[i] <= 1'b1;
                    r_addr[i] <= w_in_addr[i];
                    r_data[i] <= w_in_data[i];
                end else if (w_grant[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr      <= 1'b0;
            regwrite  <= 1'b0;
            zero_drop <= 1'b0;
            writeaddr <= '0;
            writedata <= '0;
        end else if (|w_grant) begin
            // Point at whichever requester was not just granted.
            r_rr      <= w_grant[0];
            regwrite  <= (w_gaddr != '0);
            zero_drop <= (w_gaddr == '0);
            writeaddr <= w_gaddr;
            writedata <= w_gdata;
        end else begin
            regwrite  <= 1'b0;
            zero_drop <= 1'b0;
        end
    end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter: DATA_W, default 32, width of write data.
REQ-002 Parameter: ADDR_W, default 5, width of register address (32 registers).
REQ-003 Port: clk  input  1  single clock; all state SHALL change on posedge clk only, except reset.
REQ-004 Port: reset_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: req0_valid  input  1  requester 0 write request.
REQ-006 Port: req0_addr  input  ADDR_W  requester 0 target register.
REQ-007 Port: req0_data  input  DATA_W  requester 0 write data.
REQ-008 Port: req0_ready  output  1  requester 0 may transfer this cycle.
REQ-009 Ports: req1_valid, req1_addr, req1_data, req1_ready  same directions, widths and meanings for requester 1.
REQ-010 Port: stall  input  1  freeze grants; no write issued while high.
REQ-011 Port: regwrite  output  1  registered write enable to the register file.
REQ-012 Port: writeaddr  output  ADDR_W  registered write address.
REQ-013 Port: writedata  output  DATA_W  registered write data.
REQ-014 Port: zero_drop  output  1  registered one-cycle pulse: a granted write targeted register 0 and was suppressed.

Function
REQ-015 Each requester SHALL own a one-entry pending buffer (pend_i flag, address, data).
REQ-016 Transfer on requester i SHALL occur at a posedge where req_i_valid and req_i_ready are both 1; the buffer SHALL capture address and data and set pend_i.
REQ-017 req_i_ready SHALL be combinational: (!pend_i) or (grant_i this cycle); it SHALL NOT depend on req_i_valid.
REQ-018 Grant (combinational): when stall=0 and exactly one pend_i=1, that requester SHALL be granted; when both are 1, the requester indicated by round-robin pointer rr SHALL be granted; when stall=1, no grant.
REQ-019 rr SHALL toggle to the other requester after every grant to the requester it points at; a grant to the non-pointed requester SHALL leave rr pointing at the other requester (rr always points at the requester not most recently granted).
REQ-020 On a grant edge, writeaddr/writedata SHALL load the granted buffer contents, and the granted pend_i SHALL clear unless a new transfer on the same requester occurs at that edge, in which case pend_i SHALL remain 1 with the new contents.
REQ-021 regwrite SHALL be 1 for exactly the cycle following a grant edge whose address is nonzero; otherwise 0.
REQ-022 Granted address 0: regwrite SHALL be 0, zero_drop SHALL be 1 for that cycle, writeaddr/writedata still load.
REQ-023 No grant at an edge: regwrite and zero_drop SHALL go 0; writeaddr/writedata SHALL hold.
REQ-024 Latency: transfer at edge E, sole pending, no stall -> regwrite high in cycle after E+1; sustained single-requester throughput SHALL be one write per cycle.
REQ-025 Same-address writes from both requesters SHALL be issued in grant order on consecutive cycles; the later grant defines final register content.
REQ-026 stall SHALL NOT affect transfers into empty buffers; buffers held under stall SHALL retain contents unchanged.
REQ-027 At most one write SHALL be issued per cycle; no accepted request SHALL be lost or duplicated.

Reset
REQ-028 reset_n=0 SHALL immediately clear pend_0, pend_1, regwrite, zero_drop, writeaddr, writedata to 0 and set rr to requester 0, regardless of clk.
REQ-029 While reset_n=0, req0_ready and req1_ready SHALL be 1 and no transfer SHALL be captured.
REQ-030 Reset asserted mid-operation SHALL discard pending requests without issuing them; first edge after reset_n rises SHALL behave as from reset.

Verification
REQ-031 Single request: req0 addr=5 data=0xDEADBEEF valid one cycle -> regwrite=1, writeaddr=5, writedata=0xDEADBEEF one cycle later, then regwrite=0.
REQ-032 Contention: both valid continuously, req0 addr=1, req1 addr=2 -> regwrite every cycle, writeaddr 1,2,1,2,... starting with 1 after reset.
REQ-033 Zero register: req1 addr=0 data=0x12345678 -> regwrite=0, zero_drop=1 for one cycle, req1_ready stays usable next cycle.
REQ-034 Stall: both buffers loaded, stall=1 for 3 cycles -> regwrite=0, both ready=0, contents held; stall=0 -> two writes on consecutive cycles in rr order.
REQ-035 Same address: req0 addr=7 data=0xA, req1 addr=7 data=0xB same edge, rr=0 -> writes 0xA then 0xB to register 7.
REQ-036 Async reset: assert reset_n=0 between edges with both pending -> outputs 0 immediately; after release no write of the discarded data ever appears.
